// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU opcode and boolean constants shared with the CPU decoder
package alu_pkg;

    localparam logic [3:0] ALU_NOP0  = 4'h0;
    localparam logic [3:0] ALU_ADD   = 4'h1;
    localparam logic [3:0] ALU_SUB   = 4'h2;
    localparam logic [3:0] ALU_MUL   = 4'h3;
    localparam logic [3:0] ALU_DIV   = 4'h4;
    localparam logic [3:0] ALU_AND   = 4'h5;
    localparam logic [3:0] ALU_OR    = 4'h6;
    localparam logic [3:0] ALU_XOR   = 4'h7;
    localparam logic [3:0] ALU_CMPEQ = 4'h8;
    localparam logic [3:0] ALU_CMPLT = 4'h9;
    localparam logic [3:0] ALU_CMPLE = 4'hA;
    localparam logic [3:0] ALU_SHL   = 4'hB;
    localparam logic [3:0] ALU_SHR   = 4'hC;
    localparam logic [3:0] ALU_SRA   = 4'hD;
    localparam logic [3:0] ALU_REM   = 4'hE;
    localparam logic [3:0] ALU_NOPF  = 4'hF;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    function automatic logic is_divrem(input logic [3:0] op);
        return (op == ALU_DIV) || (op == ALU_REM);
    endfunction

endpackage

// File: rtl/alu_mc_if.sv
// rtl/alu_mc_if.sv - operand/result handshake bundle between the execute stage and alu_mc
interface alu_mc_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_a;
    logic [WIDTH-1:0] data_b;
    logic [3:0]       alufn;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res;
    logic             busy;

    modport master (
        output in_valid, data_a, data_b, alufn, out_ready,
        input  in_ready, out_valid, res, busy
    );

    modport slave (
        input  in_valid, data_a, data_b, alufn, out_ready,
        output in_ready, out_valid, res, busy
    );
endinterface

// File: rtl/alu_divider.sv
// rtl/alu_divider.sv - unsigned restoring radix-2 divider, one quotient bit per enabled cycle
module alu_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             done_o
);
    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]    cnt_q;
    logic             run_q;
    logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q;
    logic [WIDTH:0]   rem_sh, diff;

    assign rem_sh = {rem_q, quo_q[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, dvs_q};

    always_comb begin
        if (!diff[WIDTH]) begin
            rem_d = diff[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_d = rem_sh[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    // done_o marks the final iteration; outputs are final on the following cycle
    assign done_o      = run_q && (cnt_q == CW'(WIDTH - 1));
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q <= 1'b0;
            cnt_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else if (clk_en) begin
            if (start_i) begin
                run_q <= 1'b1;
                cnt_q <= '0;
                quo_q <= dividend_i;
                rem_q <= '0;
                dvs_q <= divisor_i;
            end else if (run_q) begin
                quo_q <= quo_d;
                rem_q <= rem_d;
                cnt_q <= cnt_q + CW'(1);
                if (done_o) begin
                    run_q <= 1'b0;
                end
            end
        end
    end
endmodule

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU: registered single-cycle ops plus iterative signed DIV/REM
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    clk_en,
    alu_mc_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DIVIDE = 2'd1;
    localparam logic [1:0] S_SIGN   = 2'd2;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             out_valid_q, out_valid_d;
    logic             op_div_q, op_div_d, neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;

    logic [WIDTH-1:0] a, b, fast_res, abs_a, abs_b, quo, rem;
    logic [SHW-1:0]   sh;
    logic             div_by_zero, div_ovf, long_op, in_ready, accept, deliver;
    logic             div_start, div_done;

    assign a           = bus.data_a;
    assign b           = bus.data_b;
    assign sh          = b[SHW-1:0];
    assign abs_a       = a[WIDTH-1] ? -a : a;
    assign abs_b       = b[WIDTH-1] ? -b : b;
    assign div_by_zero = (b == '0);
    assign div_ovf     = (a == MIN_VAL) && (b == '1);
    assign long_op     = is_divrem(bus.alufn) && !div_by_zero && !div_ovf;

    assign in_ready = clk_en && !rst && (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign deliver  = out_valid_q && bus.out_ready && clk_en;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.res       = res_q;
    assign bus.busy      = (state_q == S_DIVIDE) || (state_q == S_SIGN);

    // DIV/REM by zero and MIN/-1 are resolved here so the divider never sees them
    always_comb begin
        fast_res = '0;
        case (bus.alufn)
            ALU_ADD:   fast_res = a + b;
            ALU_SUB:   fast_res = a - b;
            ALU_MUL:   fast_res = a * b;
            ALU_DIV:   fast_res = div_by_zero ? '1 : MIN_VAL;
            ALU_AND:   fast_res = a & b;
            ALU_OR:    fast_res = a | b;
            ALU_XOR:   fast_res = a ^ b;
            ALU_CMPEQ: fast_res = {{(WIDTH-1){1'b0}}, a == b};
            ALU_CMPLT: fast_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_CMPLE: fast_res = {{(WIDTH-1){1'b0}}, $signed(a) <= $signed(b)};
            ALU_SHL:   fast_res = a << sh;
            ALU_SHR:   fast_res = a >> sh;
            ALU_SRA:   fast_res = $unsigned($signed(a) >>> sh);
            ALU_REM:   fast_res = div_by_zero ? a : '0;
            default:   fast_res = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        res_d       = res_q;
        out_valid_d = out_valid_q;
        op_div_d    = op_div_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        div_start   = FALSE;
        if (deliver) begin
            out_valid_d = 1'b0;
        end
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (long_op) begin
                        state_d   = S_DIVIDE;
                        div_start = TRUE;
                        op_div_d  = (bus.alufn == ALU_DIV);
                        neg_quo_d = a[WIDTH-1] ^ b[WIDTH-1];
                        neg_rem_d = a[WIDTH-1];
                    end else begin
                        res_d       = fast_res;
                        out_valid_d = 1'b1;
                    end
                end
            end
            S_DIVIDE: begin
                if (div_done) begin
                    state_d = S_SIGN;
                end
            end
            S_SIGN: begin
                if (op_div_q) begin
                    res_d = neg_quo_q ? -quo : quo;
                end else begin
                    res_d = neg_rem_q ? -rem : rem;
                end
                out_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            res_q       <= '0;
            out_valid_q <= 1'b0;
            op_div_q    <= 1'b0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
        end else if (clk_en) begin
            state_q     <= state_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
            op_div_q    <= op_div_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
        end
    end

    alu_divider #(.WIDTH(WIDTH)) u_div (
        .clk         (clk),
        .rst         (rst),
        .clk_en      (clk_en),
        .start_i     (div_start),
        .dividend_i  (abs_a),
        .divisor_i   (abs_b),
        .quotient_o  (quo),
        .remainder_o (rem),
        .done_o      (div_done)
    );
endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - self-checking bench for alu_mc against an arithmetic reference model
module tb_alu_mc;
    import alu_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    logic clk_en;

    alu_mc_if #(.WIDTH(W)) bus ();

    alu_mc #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int last_deliv = 0;
    int prev_deliv = 0;
    logic [W-1:0] exp_q[$];

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int sa;
        int sb;
        int unsigned sh;
        sa = a;
        sb = b;
        sh = b % 32;
        case (op)
            4'h1: return a + b;
            4'h2: return a - b;
            4'h3: return 32'(a * b);
            4'h4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            4'h5: return a & b;
            4'h6: return a | b;
            4'h7: return a ^ b;
            4'h8: return (a == b) ? 1 : 0;
            4'h9: return (sa < sb) ? 1 : 0;
            4'hA: return (sa <= sb) ? 1 : 0;
            4'hB: return a << sh;
            4'hC: return a >> sh;
            4'hD: return sa >>> sh;
            4'hE: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
                return sa % sb;
            end
            default: return 0;
        endcase
    endfunction

    function automatic logic [W-1:0] rand_opnd();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return $urandom_range(0, 20);
            default: return $urandom();
        endcase
    endfunction

    // scoreboard: every delivered result is compared, in order, with the model
    always @(negedge clk) begin
        if (!rst && clk_en && bus.out_valid && bus.out_ready) begin
            check("queue_nonempty", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) check("res", bus.res, exp_q.pop_front());
            prev_deliv = last_deliv;
            last_deliv = cyc;
        end
    end

    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, output int waited);
        bus.alufn = op;
        bus.data_a = a;
        bus.data_b = b;
        bus.in_valid = 1'b1;
        waited = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back(ref_alu(op, a, b));
                break;
            end
            waited++;
            if (waited > 300) begin
                check("accept_timeout", waited, 0);
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        bus.in_valid = 1'b0;
        bus.data_a = $urandom();
        bus.data_b = $urandom();
        bus.alufn = 4'($urandom());
    endtask

    task automatic wait_result(output int lat, output bit ok, output logic [W-1:0] got);
        int n;
        n = 0;
        ok = 1'b1;
        got = '0;
        lat = -1;
        forever begin
            @(negedge clk);
            if (bus.out_valid) begin
                lat = cyc - acc_cyc + 1;
                got = bus.res;
                break;
            end
            if (!bus.busy || bus.in_ready) ok = 1'b0;
            n++;
            if (n > 200) begin
                check("result_timeout", n, 0);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int waited;
        bit ok;
        bit rand_done;
        logic [W-1:0] got;
        logic [W-1:0] xa, xb;
        logic [3:0] op;

        rst = 1'b1;
        clk_en = 1'b1;
        bus.in_valid = 1'b0;
        bus.data_a = '0;
        bus.data_b = '0;
        bus.alufn = 4'h0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_res", bus.res, 0);
        check("rst_busy", bus.busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        send(ALU_ADD, 32'h7FFF_FFFF, 32'h1, waited);
        check("b2b_first_wait", waited, 0);
        send(ALU_SUB, 32'h0, 32'h1, waited);
        check("b2b_second_wait", waited, 0);
        drain();
        check("b2b_spacing", last_deliv - prev_deliv, 1);

        send(ALU_DIV, 32'hFFFF_FFF9, 32'h2, waited);
        wait_result(lat, ok, got);
        check("div_latency", lat, 34);
        check("div_busy_blocked", ok, 1);
        check("div_value", got, 32'hFFFF_FFFD);
        send(ALU_REM, 32'hFFFF_FFF9, 32'h2, waited);
        wait_result(lat, ok, got);
        check("rem_latency", lat, 34);
        check("rem_busy_blocked", ok, 1);
        check("rem_value", got, 32'hFFFF_FFFF);

        send(ALU_DIV, 32'h5, 32'h0, waited);
        wait_result(lat, ok, got);
        check("div0_latency", lat, 1);
        check("div0_value", got, 32'hFFFF_FFFF);
        send(ALU_REM, 32'h5, 32'h0, waited);
        wait_result(lat, ok, got);
        check("rem0_latency", lat, 1);
        check("rem0_value", got, 32'h5);
        send(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, waited);
        wait_result(lat, ok, got);
        check("divovf_latency", lat, 1);
        check("divovf_value", got, 32'h8000_0000);

        send(ALU_SRA, 32'h8000_0000, 32'h24, waited);
        wait_result(lat, ok, got);
        check("sra_value", got, 32'hF800_0000);
        send(ALU_SHR, 32'h8000_0000, 32'h24, waited);
        wait_result(lat, ok, got);
        check("shr_value", got, 32'h0800_0000);
        send(ALU_CMPLT, 32'hFFFF_FFFF, 32'h1, waited);
        wait_result(lat, ok, got);
        check("cmplt_value", got, 32'h1);

        xa = 32'hDEAD_BEEF;
        xb = 32'h1234_5678;
        bus.out_ready = 1'b0;
        send(ALU_XOR, xa, xb, waited);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_out_valid", bus.out_valid, 1);
            check("hold_res", bus.res, xa ^ xb);
            check("hold_in_ready", bus.in_ready, 0);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        send(ALU_ADD, 32'h10, 32'h20, waited);
        check("accept_on_ready_rise", waited, 0);
        drain();

        send(ALU_DIV, 32'd100, 32'd7, waited);
        repeat (10) @(posedge clk);
        #1;
        clk_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        clk_en = 1'b1;
        wait_result(lat, ok, got);
        check("stall_latency", lat, 37);
        check("stall_value", got, 32'hE);

        send(ALU_DIV, 32'd1000, 32'd3, waited);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_busy", bus.busy, 0);
        @(posedge clk);
        #1;
        send(ALU_ADD, 32'd3, 32'd4, waited);
        wait_result(lat, ok, got);
        check("post_rst_add", got, 32'd7);
        check("post_rst_latency", lat, 1);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("no_stale_result", bus.out_valid, 0);
        @(posedge clk);
        #1;

        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    op = 4'($urandom_range(0, 15));
                    send(op, rand_opnd(), rand_opnd(), waited);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    clk_en = ($urandom_range(0, 3) != 0);
                    bus.out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        clk_en = 1'b1;
        bus.out_ready = 1'b1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
